// File: rtl/fft_pkg.sv
// Shared FFT definitions: FSM state encoding, per-stage stride, stage count
// and the (stage, PE, lane) -> frame-buffer index helper.
package fft_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_ISSUE    = 2'd1;
    localparam state_t ST_WAIT_RES = 2'd2;
    localparam state_t ST_DONE     = 2'd3;

    function automatic int numStages(input int nPoints);
        return ($clog2(nPoints) + 1) / 2;
    endfunction

    function automatic int stageStride(input int nPoints, input int k);
        int s;
        s = nPoints >> (2 * (k + 1));
        return (s < 1) ? 1 : s;
    endfunction

    // Lane l of a PE sits one stride above lane l-1 inside its group of 4*S points.
    function automatic int bufIndex(input int nPoints, input int k, input int p, input int l);
        int s;
        s = stageStride(nPoints, k);
        return (p / s) * 4 * s + (p % s) + l * s;
    endfunction

endpackage

// File: rtl/fft_stage_shuffle_if.sv
// Frame, PE-issue and result handshakes of fft_stage_shuffle bundled together.
// slave is the shuffle block's view, master the surrounding environment's.
interface fft_stage_shuffle_if #(
    parameter int FORMAT_WIDTH = 9,
    parameter int N_POINTS     = 32
);
    import fft_pkg::*;

    localparam int W       = FORMAT_WIDTH * N_POINTS;
    localparam int STAGE_W = $clog2(numStages(N_POINTS) + 1);

    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_real;
    logic [W-1:0]       in_imag;
    logic               pe_valid;
    logic               pe_ready;
    logic [W-1:0]       pe_real;
    logic [W-1:0]       pe_imag;
    logic               res_valid;
    logic [W-1:0]       res_real;
    logic [W-1:0]       res_imag;
    logic [STAGE_W-1:0] stage;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_real;
    logic [W-1:0]       out_imag;

    modport slave (
        input  in_valid, in_real, in_imag, pe_ready, res_valid, res_real, res_imag, out_ready,
        output in_ready, pe_valid, pe_real, pe_imag, stage, busy, out_valid, out_real, out_imag
    );

    modport master (
        output in_valid, in_real, in_imag, pe_ready, res_valid, res_real, res_imag, out_ready,
        input  in_ready, pe_valid, pe_real, pe_imag, stage, busy, out_valid, out_real, out_imag
    );

endinterface

// File: rtl/shuffle_index_map.sv
// Combinational map from (stage, PE, lane) to the frame-buffer index that lane
// is issued from and written back to.
module shuffle_index_map
    import fft_pkg::*;
#(
    parameter  int N_POINTS   = 32,
    localparam int NUM_STAGES = numStages(N_POINTS),
    localparam int STAGE_W    = $clog2(NUM_STAGES + 1),
    localparam int IDX_W      = $clog2(N_POINTS)
) (
    input  logic [STAGE_W-1:0] stage_i,
    input  logic [7:0]         pe_i,
    input  logic [1:0]         lane_i,
    output logic [IDX_W-1:0]   idx_o
);

    // Unrolling over stages keeps every stride a constant, so no real divider is built.
    always_comb begin
        idx_o = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (int'(stage_i) == k) begin
                idx_o = IDX_W'(bufIndex(N_POINTS, k, int'(pe_i), int'(lane_i)));
            end
        end
    end

endmodule

// File: rtl/fft_stage_shuffle.sv
// Radix-4 FFT stage sequencer: holds one frame, issues shuffled slices to the PE
// array each stage and writes results back in place. SHUFFLE_FRAME_CNT_EN adds frame_cnt.
module fft_stage_shuffle
    import fft_pkg::*;
#(
    parameter int FORMAT_WIDTH = 9,
    parameter int N_POINTS     = 32
) (
    input  logic               clk,
    input  logic               rst,
    fft_stage_shuffle_if.slave bus
`ifdef SHUFFLE_FRAME_CNT_EN
    ,
    output logic [31:0]        frame_cnt
`endif
);

    localparam int FW         = FORMAT_WIDTH;
    localparam int W          = FORMAT_WIDTH * N_POINTS;
    localparam int NUM_PE     = N_POINTS / 4;
    localparam int NUM_STAGES = numStages(N_POINTS);
    localparam int STAGE_W    = $clog2(NUM_STAGES + 1);
    localparam int IDX_W      = $clog2(N_POINTS);

    state_t             state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [FW-1:0]      bufReal_q [N_POINTS];
    logic [FW-1:0]      bufReal_d [N_POINTS];
    logic [FW-1:0]      bufImag_q [N_POINTS];
    logic [FW-1:0]      bufImag_d [N_POINTS];
    logic [W-1:0]       peReal_q, peReal_d, peImag_q, peImag_d;
    logic [W-1:0]       outReal, outImag;
    logic               inReady_q, peValid_q, outValid_q;
    logic [IDX_W-1:0]   issueIdx [NUM_PE][4];
    logic [IDX_W-1:0]   wbIdx    [NUM_PE][4];

    // Issue side looks at the next stage so pe data is ready on ISSUE entry.
    for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
        for (genvar l = 0; l < 4; l++) begin : g_lane
            shuffle_index_map #(.N_POINTS(N_POINTS)) u_issueMap (
                .stage_i(stage_d), .pe_i(8'(p)), .lane_i(2'(l)), .idx_o(issueIdx[p][l])
            );
            shuffle_index_map #(.N_POINTS(N_POINTS)) u_wbMap (
                .stage_i(stage_q), .pe_i(8'(p)), .lane_i(2'(l)), .idx_o(wbIdx[p][l])
            );
        end
    end

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        bufReal_d = bufReal_q;
        bufImag_d = bufImag_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && inReady_q) begin
                    for (int i = 0; i < N_POINTS; i++) begin
                        bufReal_d[i] = bus.in_real[i*FW +: FW];
                        bufImag_d[i] = bus.in_imag[i*FW +: FW];
                    end
                    stage_d = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.pe_ready) state_d = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (bus.res_valid) begin
                    for (int p = 0; p < NUM_PE; p++) begin
                        for (int l = 0; l < 4; l++) begin
                            bufReal_d[wbIdx[p][l]] = bus.res_real[p*4*FW + (3-l)*FW +: FW];
                            bufImag_d[wbIdx[p][l]] = bus.res_imag[p*4*FW + (3-l)*FW +: FW];
                        end
                    end
                    stage_d = stage_q + 1'b1;
                    state_d = (stage_d == STAGE_W'(NUM_STAGES)) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        peReal_d = peReal_q;
        peImag_d = peImag_q;
        if (state_d == ST_ISSUE) begin
            for (int p = 0; p < NUM_PE; p++) begin
                for (int l = 0; l < 4; l++) begin
                    peReal_d[p*4*FW + (3-l)*FW +: FW] = bufReal_d[issueIdx[p][l]];
                    peImag_d[p*4*FW + (3-l)*FW +: FW] = bufImag_d[issueIdx[p][l]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            stage_q    <= '0;
            bufReal_q  <= '{default: '0};
            bufImag_q  <= '{default: '0};
            peReal_q   <= '0;
            peImag_q   <= '0;
            inReady_q  <= 1'b0;
            peValid_q  <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            bufReal_q  <= bufReal_d;
            bufImag_q  <= bufImag_d;
            peReal_q   <= peReal_d;
            peImag_q   <= peImag_d;
            inReady_q  <= (state_d == ST_IDLE);
            peValid_q  <= (state_d == ST_ISSUE);
            outValid_q <= (state_d == ST_DONE);
        end
    end

    always_comb begin
        outReal = '0;
        outImag = '0;
        for (int i = 0; i < N_POINTS; i++) begin
            outReal[i*FW +: FW] = bufReal_q[i];
            outImag[i*FW +: FW] = bufImag_q[i];
        end
    end

    assign bus.in_ready  = inReady_q;
    assign bus.pe_valid  = peValid_q;
    assign bus.pe_real   = peReal_q;
    assign bus.pe_imag   = peImag_q;
    assign bus.stage     = stage_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_valid = outValid_q;
    assign bus.out_real  = outReal;
    assign bus.out_imag  = outImag;

`ifdef SHUFFLE_FRAME_CNT_EN
    logic [31:0] frameCnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            frameCnt_q <= '0;
        end else if (outValid_q && bus.out_ready) begin
            frameCnt_q <= frameCnt_q + 32'd1;
        end
    end

    assign frame_cnt = frameCnt_q;
`endif

endmodule
